// File: rtl/router_pkg.sv
// Shared definitions for the multi-PE weight router.
//   state_t      : controller state encoding (IDLE/READ/DRAIN/DONE)
//   MODE_*       : values of the latched bcast_mode bit
//   wpf()        : words per filter for a given kernel side
package router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_UNICAST = 1'b0;
    localparam logic MODE_BCAST   = 1'b1;

    function automatic int wpf(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

endpackage

// File: rtl/wght_idx_gen.sv
// Destination index generator for spad writes.
// Nested counters: element index 0..WPF-1 (wraps), PE index 0..NUM_PE-1
// advancing on each element wrap. Counters hold the index of the write
// currently being captured into the output registers.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart both counters at 0 (start of a transfer)
//   advance     : a write is being captured this cycle; step the counters
//   bcast       : latched broadcast mode (only one filter pass)
//   elem_idx    : element index, zero-extended to the spad address width
//   pe_onehot   : one-hot of the current PE index
//   last_write  : the write being captured is the final one of the transfer
module wght_idx_gen
    import router_pkg::*;
#(
    parameter int WPF                = 9,
    parameter int NUM_PE             = 3,
    parameter int ADDR_BITWIDTH_SPAD = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          advance,
    input  logic                          bcast,
    output logic [ADDR_BITWIDTH_SPAD-1:0] elem_idx,
    output logic [NUM_PE-1:0]             pe_onehot,
    output logic                          last_write
);

    localparam int ELEM_W = (WPF > 1)    ? $clog2(WPF)    : 1;
    localparam int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [ELEM_W-1:0] elem_cnt;
    logic [PE_W-1:0]   pe_cnt;
    logic              elem_wrap;
    logic              pe_wrap;

    assign elem_wrap = (elem_cnt == ELEM_W'(WPF - 1));
    assign pe_wrap   = (pe_cnt == PE_W'(NUM_PE - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            elem_cnt <= '0;
            pe_cnt   <= '0;
        end else if (advance) begin
            if (elem_wrap) begin
                elem_cnt <= '0;
                pe_cnt   <= pe_wrap ? '0 : pe_cnt + 1'b1;
            end else begin
                elem_cnt <= elem_cnt + 1'b1;
            end
        end
    end

    assign elem_idx   = ADDR_BITWIDTH_SPAD'(elem_cnt);
    assign pe_onehot  = NUM_PE'(1) << pe_cnt;
    // In broadcast only one filter pass is made, so the element wrap alone ends it.
    assign last_write = elem_wrap && ((bcast == MODE_BCAST) || pe_wrap);

endmodule

// File: rtl/router_weight_mc.sv
// Multi-PE weight router: streams one KERNEL_SIZE x KERNEL_SIZE filter
// (broadcast) or NUM_PE consecutive filters (unicast) from the weight GLB
// into the PE weight spads.
//
// state | meaning
// IDLE  | waiting for load_spad_ctrl; latches mode and request count
// READ  | one GLB read per cycle at consecutive addresses
// DRAIN | reads finished, waiting for the final spad write
// DONE  | one-cycle completion pulse
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   load_spad_ctrl    : start pulse (honoured in IDLE only)
//   bcast_mode        : 1 = broadcast, 0 = unicast; sampled with start
//   r_data_glb_wght   : GLB read data, valid one cycle after the request
//   r_addr_glb_wght   : GLB read address
//   read_req_glb_wght : GLB read request
//   w_data_spad       : weight word to the spads
//   w_addr_spad       : element index within the filter
//   load_en_spad      : per-PE write enable
//   busy, done        : transfer in progress / completion pulse
module router_weight_mc
    import router_pkg::*;
#(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_GLB  = 10,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int KERNEL_SIZE        = 3,
    parameter int NUM_PE             = 3,
    parameter int W_READ_ADDR        = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_spad_ctrl,
    input  logic                          bcast_mode,
    input  logic [DATA_BITWIDTH-1:0]      r_data_glb_wght,
    output logic [ADDR_BITWIDTH_GLB-1:0]  r_addr_glb_wght,
    output logic                          read_req_glb_wght,
    output logic [DATA_BITWIDTH-1:0]      w_data_spad,
    output logic [ADDR_BITWIDTH_SPAD-1:0] w_addr_spad,
    output logic [NUM_PE-1:0]             load_en_spad,
    output logic                          busy,
    output logic                          done
);

    localparam int WPF   = wpf(KERNEL_SIZE);
    localparam int N_MAX = WPF * NUM_PE;
    localparam int CNT_W = $clog2(N_MAX + 1);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE = ADDR_BITWIDTH_GLB'(W_READ_ADDR);

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          req_left;    // requests still to issue after the current one
    logic                      mode_q;
    logic                      rd_valid_q;  // GLB data on r_data_glb_wght is valid this cycle
    logic                      last_q;      // final write is on the spad outputs this cycle
    logic                      start;
    logic [ADDR_BITWIDTH_SPAD-1:0] elem_idx;
    logic [NUM_PE-1:0]         pe_onehot;
    logic                      last_write;

    assign start = (state == IDLE) && load_spad_ctrl;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (load_spad_ctrl)  state_nxt = READ;
            READ:  if (req_left == '0)  state_nxt = DRAIN;
            DRAIN: if (last_q)          state_nxt = DONE;
            DONE:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read_req_glb_wght = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        case (state)
            READ:    begin read_req_glb_wght = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Read side: address counter wraps naturally at the GLB address width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_glb_wght <= BASE;
            req_left        <= '0;
            mode_q          <= MODE_UNICAST;
            rd_valid_q      <= 1'b0;
        end else begin
            rd_valid_q <= read_req_glb_wght;
            if (state == IDLE) begin
                r_addr_glb_wght <= BASE;
                if (load_spad_ctrl) begin
                    mode_q   <= bcast_mode;
                    req_left <= (bcast_mode == MODE_BCAST) ? CNT_W'(WPF - 1) : CNT_W'(N_MAX - 1);
                end
            end else if ((state == READ) && (req_left != '0)) begin
                r_addr_glb_wght <= r_addr_glb_wght + 1'b1;
                req_left        <= req_left - 1'b1;
            end
        end
    end

    // Write side: GLB data is registered straight onto the spad bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_data_spad  <= '0;
            w_addr_spad  <= '0;
            load_en_spad <= '0;
            last_q       <= 1'b0;
        end else begin
            last_q       <= rd_valid_q && last_write;
            load_en_spad <= '0;
            if (rd_valid_q) begin
                w_data_spad  <= r_data_glb_wght;
                w_addr_spad  <= elem_idx;
                load_en_spad <= (mode_q == MODE_BCAST) ? {NUM_PE{1'b1}} : pe_onehot;
            end
        end
    end

    wght_idx_gen #(
        .WPF                (WPF),
        .NUM_PE             (NUM_PE),
        .ADDR_BITWIDTH_SPAD (ADDR_BITWIDTH_SPAD)
    ) u_idx (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .advance    (rd_valid_q),
        .bcast      (mode_q),
        .elem_idx   (elem_idx),
        .pe_onehot  (pe_onehot),
        .last_write (last_write)
    );

endmodule

// File: tb/tb_router_weight_mc.sv
// Bench for router_weight_mc: two instances (base 0x010 and 0x3FC) share
// the same control stimulus; a cycle-indexed transfer model predicts every
// output, and a few literal pins anchor that model.
module tb_router_weight_mc;

    localparam int WPF = 9;
    localparam int NPE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_spad_ctrl;
    logic        bcast_mode;
    logic [15:0] rdata_a = '0, rdata_b = '0;
    logic [9:0]  raddr_a, raddr_b;
    logic        req_a, req_b;
    logic [15:0] wdata_a, wdata_b;
    logic [8:0]  waddr_a, waddr_b;
    logic [2:0]  len_a, len_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [15:0] glb [1024];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    router_weight_mc #(.KERNEL_SIZE(3), .NUM_PE(3), .W_READ_ADDR('h010)) dut_a (
        .clk(clk), .reset(reset), .load_spad_ctrl(load_spad_ctrl), .bcast_mode(bcast_mode),
        .r_data_glb_wght(rdata_a), .r_addr_glb_wght(raddr_a), .read_req_glb_wght(req_a),
        .w_data_spad(wdata_a), .w_addr_spad(waddr_a), .load_en_spad(len_a),
        .busy(busy_a), .done(done_a));

    router_weight_mc #(.KERNEL_SIZE(3), .NUM_PE(3), .W_READ_ADDR('h3FC)) dut_b (
        .clk(clk), .reset(reset), .load_spad_ctrl(load_spad_ctrl), .bcast_mode(bcast_mode),
        .r_data_glb_wght(rdata_b), .r_addr_glb_wght(raddr_b), .read_req_glb_wght(req_b),
        .w_data_spad(wdata_b), .w_addr_spad(waddr_b), .load_en_spad(len_b),
        .busy(busy_b), .done(done_b));

    // GLB banks with one-cycle read latency.
    always @(posedge clk) begin
        if (req_a) rdata_a <= glb[raddr_a];
        if (req_b) rdata_b <= glb[raddr_b];
    end

    // Transfer model: m_k is the cycle index relative to the accepted start.
    bit m_active = 0;
    bit m_mode   = 0;
    bit m_fresh  = 1;
    int m_k      = 0;

    function automatic int total(input bit bc);
        return bc ? WPF : WPF * NPE;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0;
            m_fresh  = 1;
        end else if (m_active) begin
            if (m_k == total(m_mode) + 3) m_active = 0;
            else                          m_k++;
        end else if (load_spad_ctrl) begin
            m_active = 1;
            m_k      = 1;
            m_mode   = bcast_mode;
            m_fresh  = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input int base,
                             input logic [9:0] raddr, input logic req,
                             input logic [15:0] wdata, input logic [8:0] waddr,
                             input logic [2:0] len, input logic busy, input logic done);
        int n, j;
        bit rq, wr;
        logic [2:0] e_len;
        n  = total(m_mode);
        rq = m_active && (m_k <= n);
        wr = m_active && (m_k >= 3) && (m_k <= n + 2);
        j  = m_k - 3;
        e_len = 3'b000;
        if (wr) e_len = m_mode ? 3'b111 : 3'(1 << (j / WPF));
        chk({tag, "_req"},  32'(req),  32'(rq));
        chk({tag, "_busy"}, 32'(busy), 32'(m_active && (m_k <= n + 2)));
        chk({tag, "_done"}, 32'(done), 32'(m_active && (m_k == n + 3)));
        chk({tag, "_len"},  32'(len),  32'(e_len));
        if (rq) chk({tag, "_raddr"}, 32'(raddr), 32'((base + m_k - 1) % 1024));
        if (wr) begin
            chk({tag, "_wdata"}, 32'(wdata), 32'(glb[(base + j) % 1024]));
            chk({tag, "_waddr"}, 32'(waddr), 32'(j % WPF));
        end
        if (!m_active && m_fresh) begin
            chk({tag, "_rst_raddr"}, 32'(raddr), 32'(base));
            chk({tag, "_rst_wdata"}, 32'(wdata), 32'(0));
            chk({tag, "_rst_waddr"}, 32'(waddr), 32'(0));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut("a", 'h010, raddr_a, req_a, wdata_a, waddr_a, len_a, busy_a, done_a);
            check_dut("b", 'h3FC, raddr_b, req_b, wdata_b, waddr_b, len_b, busy_b, done_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) glb[i] = 16'(i);
        reset          = 1'b1;
        load_spad_ctrl = 1'b0;
        bcast_mode     = 1'b0;
        repeat (3) step();
        chk_en = 1;
        reset  = 1'b0;
        step();

        // Broadcast transfer, with ignored starts while busy and in DONE.
        load_spad_ctrl = 1'b1; bcast_mode = 1'b1;
        step();                                   // cycle 1
        load_spad_ctrl = 1'b0; bcast_mode = 1'b0;
        chk("pin_a_raddr_c1", 32'(raddr_a), 32'h010);
        chk("pin_b_raddr_c1", 32'(raddr_b), 32'h3FC);
        chk("pin_a_busy_c1",  32'(busy_a),  32'h1);
        repeat (2) step();                        // cycle 3
        chk("pin_a_len_c3",   32'(len_a),   32'h7);
        chk("pin_a_wdata_c3", 32'(wdata_a), 32'h0010);
        chk("pin_b_wdata_c3", 32'(wdata_b), 32'h03FC);
        repeat (2) step();                        // cycle 5
        chk("pin_b_raddr_wrap", 32'(raddr_b), 32'h000);
        load_spad_ctrl = 1'b1;
        step();                                   // cycle 6
        load_spad_ctrl = 1'b0; bcast_mode = 1'b1;
        repeat (5) step();                        // cycle 11
        chk("pin_a_wdata_c11", 32'(wdata_a), 32'h0018);
        chk("pin_a_waddr_c11", 32'(waddr_a), 32'h8);
        step();                                   // cycle 12
        chk("pin_a_done_c12", 32'(done_a), 32'h1);
        chk("pin_a_busy_c12", 32'(busy_a), 32'h0);
        load_spad_ctrl = 1'b1; bcast_mode = 1'b0;
        step();                                   // cycle 13 (idle)
        chk("pin_a_done_c13", 32'(done_a), 32'h0);
        chk("pin_a_req_c13",  32'(req_a),  32'h0);

        // Unicast transfer started one cycle after DONE.
        step();                                   // unicast cycle 1
        load_spad_ctrl = 1'b0; bcast_mode = 1'b1;
        chk("pin_u_raddr_c1", 32'(raddr_a), 32'h010);
        repeat (11) step();                       // cycle 12
        chk("pin_u_len_c12",   32'(len_a),   32'h2);
        chk("pin_u_wdata_c12", 32'(wdata_a), 32'h0019);
        chk("pin_u_waddr_c12", 32'(waddr_a), 32'h0);
        repeat (17) step();                       // cycle 29
        chk("pin_u_len_c29",   32'(len_a),   32'h4);
        chk("pin_u_wdata_c29", 32'(wdata_a), 32'h002A);
        chk("pin_u_waddr_c29", 32'(waddr_a), 32'h8);
        step();                                   // cycle 30
        chk("pin_u_done_c30", 32'(done_a), 32'h1);
        repeat (3) step();

        // Reset asserted in cycle 6 of a unicast transfer.
        load_spad_ctrl = 1'b1; bcast_mode = 1'b0;
        step();
        load_spad_ctrl = 1'b0;
        repeat (5) step();                        // cycle 6
        reset = 1'b1;
        step();                                   // cycle 7
        reset = 1'b0;
        chk("pin_rst_len",   32'(len_a),   32'h0);
        chk("pin_rst_req",   32'(req_a),   32'h0);
        chk("pin_rst_raddr", 32'(raddr_a), 32'h010);
        chk("pin_rst_wdata", 32'(wdata_a), 32'h0);
        repeat (4) step();
        load_spad_ctrl = 1'b1; bcast_mode = 1'($urandom);
        step();
        load_spad_ctrl = 1'b0;
        repeat (35) step();

        // Randomized traffic over random GLB contents.
        for (int i = 0; i < 1024; i++) glb[i] = 16'($urandom);
        for (int c = 0; c < 4000; c++) begin
            load_spad_ctrl = ($urandom_range(0, 5) == 0);
            bcast_mode     = 1'($urandom);
            reset          = ($urandom_range(0, 299) == 0);
            step();
        end
        load_spad_ctrl = 1'b0;
        reset          = 1'b0;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
